// File: rtl/pb_step_sequencer_pkg.sv
// Shared types and default timing for the push-button step sequencer.
// The defaults match the debouncer and program-counter blocks.
package pb_step_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHeld   = 2'd1,
    StRepeat = 2'd2
  } seq_state_e;

  localparam int unsigned DefHoldCycles   = 50_000_000;
  localparam int unsigned DefRepeatCycles = 10_000_000;
  localparam int unsigned DefMaxPending   = 7;

  // The timer width must hold max(hold, repeat) - 1, which is the largest value ever loaded.
  function automatic int unsigned timer_width(input int unsigned hold, input int unsigned rep);
    int unsigned longest;
    longest = (hold > rep) ? hold : rep;
    return (longest < 2) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/pb_step_sequencer_cycle_timer.sv
// Loadable down-counter with a zero flag. A load takes priority over a decrement,
// and the counter holds at zero instead of wrapping.
module pb_step_sequencer_cycle_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/pb_step_sequencer.sv
// Turns the debounced button level into program-counter step requests. A press gives one step,
// and a long hold auto-repeats. Steps queue in a saturating counter that is drained by step_ack.
module pb_step_sequencer
  import pb_step_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = DefHoldCycles,
  parameter int unsigned REPEAT_CYCLES = DefRepeatCycles,
  parameter int unsigned MAX_PENDING   = DefMaxPending,
  localparam int unsigned CW           = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          PB_state,
  input  logic          step_ack,
  output logic          step_req,
  output logic [CW-1:0] pending,
  output logic          repeating,
  output logic          overflow
);

  localparam int unsigned TW = timer_width(HOLD_CYCLES, REPEAT_CYCLES);

  localparam logic [TW-1:0] HoldLoad   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] RepeatLoad = TW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] MaxPend    = CW'(MAX_PENDING);

  seq_state_e    state_q, state_d;
  logic          pb_q;
  logic          armed_q, armed_d;
  logic [CW-1:0] pending_q, pending_d;
  logic          overflow_q, overflow_d;

  logic          press;
  logic          step_evt;
  logic          ack;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_dec;
  logic          tmr_zero;

  pb_step_sequencer_cycle_timer #(
    .Width (TW)
  ) u_cycle_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // A level held through reset must be released once before it can count as a press.
  assign armed_d = armed_q | ~PB_state;
  assign press   = PB_state & ~pb_q & armed_q;

  always_comb begin
    state_d  = state_q;
    step_evt = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (press) begin
          step_evt = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = HoldLoad;
          state_d  = StHeld;
        end
      end
      StHeld: begin
        if (!PB_state) begin
          state_d = StIdle;
        end else if (tmr_zero) begin
          step_evt = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = RepeatLoad;
          state_d  = StRepeat;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      StRepeat: begin
        if (!PB_state) begin
          state_d = StIdle;
        end else if (tmr_zero) begin
          step_evt = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = RepeatLoad;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ack = step_ack & step_req;

  // A step that lands together with an accepted ack passes straight through, even when full.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (step_evt && !ack) begin
      if (pending_q == MaxPend) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + CW'(1);
      end
    end else if (!step_evt && ack) begin
      pending_d = pending_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pb_q       <= 1'b0;
      armed_q    <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pb_q       <= PB_state;
      armed_q    <= armed_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign step_req  = (pending_q != '0);
  assign pending   = pending_q;
  assign repeating = (state_q == StRepeat);
  assign overflow  = overflow_q;

endmodule
